// File: rtl/uart_rx_ip.sv
// uart_rx_ip: memory-mapped 8N1 UART receiver. A two-flop synchroniser feeds
// a bit-timing FSM that deserialises frames LSB-first into a small circular
// RX FIFO. The CPU sees RXDATA (pop on read), STATUS (W1C sticky flags) and
// BAUDDIV (clocks per bit, latched at each frame start).
module uart_rx_ip #(
  parameter int unsigned DEFAULT_DIV = 434,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic [3:0]  wstrb,
  output logic        wready,
  input  logic [31:0] raddr,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic        i_uart_rx,
  output logic        o_rx_irq
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_e;

  // Synchroniser and edge detect
  logic rx_meta, rx_s, rx_prev, rx_fall;

  // Receiver datapath and FSM
  rx_state_e   state, next_state;
  logic [15:0] cnt, div_lat, half_m1;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        tick, frame_start, bit_sample, push_req, ferr_set, cnt_run;

  // Registers and FIFO
  logic [15:0] bauddiv, baud_merged, baud_next;
  logic        wr_baud, wr_stat;
  logic        overrun, frame_err;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic        not_empty, full, pop, push_ok, ovr_set;
  logic [31:0] rdata_next;

  // Address bits and byte lanes the block does not decode
  logic unused_bits;
  assign unused_bits = ^{waddr[31:4], waddr[1:0], raddr[31:4], raddr[1:0],
                         wdata[31:16], wstrb[3:2]};

  // Two-flop synchroniser plus a delayed copy for falling-edge detection;
  // preset high so leaving reset never looks like a start bit
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so each flop captures the pre-edge value
    // of its neighbour; blocking here would collapse the chain into one flop.
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign rx_fall = rx_prev & ~rx_s;

  // Start bit is sampled half a bit in; all later samples one full bit apart
  assign half_m1 = (div_lat >> 1) - 16'd1;
  assign tick    = (state == S_START) ? (cnt == half_m1) : (cnt == div_lat - 16'd1);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch forms.
    next_state = state;
    case (state)
      S_IDLE:  if (rx_fall) next_state = S_START;
      S_START: if (tick) next_state = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (tick && bit_idx == 3'd7) next_state = S_STOP;
      S_STOP:  if (tick) next_state = rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // FSM outputs: counter enable, sample strobes, push and framing-error events
  always_comb begin
    frame_start = 1'b0;
    bit_sample  = 1'b0;
    push_req    = 1'b0;
    ferr_set    = 1'b0;
    cnt_run     = 1'b0;
    case (state)
      S_IDLE:  frame_start = rx_fall;
      S_START: cnt_run = !tick;
      S_DATA: begin
        cnt_run    = !tick;
        bit_sample = tick;
      end
      S_STOP: begin
        cnt_run  = !tick;
        push_req = tick & rx_s;
        ferr_set = tick & ~rx_s;
      end
      default: ;
    endcase
  end

  // Bit timer, bit index and LSB-first shift register; divisor frozen per frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= 16'd0;
      div_lat <= 16'(DEFAULT_DIV);
      bit_idx <= 3'd0;
      shift   <= 8'd0;
    end else begin
      if (frame_start) div_lat <= bauddiv;
      cnt <= cnt_run ? cnt + 16'd1 : 16'd0;
      if (state == S_START)  bit_idx <= 3'd0;
      else if (bit_sample)   bit_idx <= bit_idx + 3'd1;
      if (bit_sample) shift <= {rx_s, shift[7:1]};
    end
  end

  // Register write decode; BAUDDIV honours byte lanes 0/1 and clamps tiny values
  assign wr_baud     = wen && (waddr[3:2] == 2'd2);
  assign wr_stat     = wen && (waddr[3:2] == 2'd1) && wstrb[0];
  assign baud_merged = {wstrb[1] ? wdata[15:8] : bauddiv[15:8],
                        wstrb[0] ? wdata[7:0]  : bauddiv[7:0]};
  assign baud_next   = (baud_merged < MIN_DIV) ? MIN_DIV : baud_merged;

  // FIFO control: a pop on an empty FIFO is ignored, a push into a full FIFO
  // is only accepted when the same cycle frees a slot
  assign not_empty = (count != '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = ren && (raddr[3:2] == 2'd0) && not_empty;
  assign push_ok   = push_req && (!full || pop);
  assign ovr_set   = push_req && full && !pop;
  assign o_rx_irq  = not_empty;

  // FIFO storage, written only on an accepted push
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count gates every read, so stale entries are
    // never visible and the array can map onto plain registers or LUT RAM.
    if (push_ok) mem[wr_ptr] <= shift;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  // Control registers: divisor and sticky flags (a new event wins over a clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bauddiv   <= 16'(DEFAULT_DIV);
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_baud) bauddiv <= baud_next;
      overrun   <= (overrun   && !(wr_stat && wdata[2])) || ovr_set;
      frame_err <= (frame_err && !(wr_stat && wdata[3])) || ferr_set;
    end
  end

  // Read data multiplexer
  always_comb begin
    rdata_next = 32'd0;
    case (raddr[3:2])
      2'd0:    rdata_next = not_empty ? {24'd0, mem[rd_ptr]} : 32'd0;
      2'd1:    rdata_next = {28'd0, frame_err, overrun, full, not_empty};
      2'd2:    rdata_next = {16'd0, bauddiv};
      default: rdata_next = 32'd0;
    endcase
  end

  // Bus handshake: registered read data and single-cycle acknowledges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata  <= 32'd0;
      rvalid <= 1'b0;
      wready <= 1'b0;
    end else begin
      if (ren) rdata <= rdata_next;
      rvalid <= ren;
      wready <= wen;
    end
  end

endmodule

// File: tb/tb_uart_rx_ip.sv
// Self-checking bench for uart_rx_ip: serial frames are driven bit by bit and
// results are compared against a queue-based model of the receive FIFO/flags.
`timescale 1ns/1ps
module tb_uart_rx_ip;

  localparam int DEPTH   = 4;
  localparam int DEF_DIV = 434;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] waddr = '0, wdata = '0, raddr = '0;
  logic        wen = 1'b0, ren = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        wready, rvalid, o_rx_irq;
  logic [31:0] rdata;
  logic        uart_line = 1'b1;

  uart_rx_ip #(.DEFAULT_DIV(DEF_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb), .wready(wready),
    .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid),
    .i_uart_rx(uart_line), .o_rx_irq(o_rx_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [7:0] model_q[$];
  bit         model_ovr = 0, model_ferr = 0;
  int         cur_div = DEF_DIV;

  function automatic void model_rx(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)                    model_ferr = 1;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else                             model_ovr = 1;
  endfunction

  function automatic logic [31:0] model_status();
    return {28'd0, model_ferr, model_ovr, model_q.size() == DEPTH, model_q.size() != 0};
  endfunction

  function automatic logic [31:0] model_pop();
    if (model_q.size() == 0) return 32'd0;
    return {24'd0, model_q.pop_front()};
  endfunction

  function automatic logic [15:0] model_baud(input logic [15:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [15:0] v;
    v = old;
    if (s[0]) v[7:0]  = d[7:0];
    if (s[1]) v[15:8] = d[15:8];
    return (v < 16'd4) ? 16'd4 : v;
  endfunction

  // Bus helpers
  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic ack);
    @(negedge clk);
    waddr = {28'd0, addr}; wdata = data; wstrb = strb; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0; wstrb = 4'd0; ack = wready;
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] data, output logic vld);
    @(negedge clk);
    raddr = {28'd0, addr}; ren = 1'b1;
    @(negedge clk);
    ren = 1'b0; data = rdata; vld = rvalid;
  endtask

  // Serial driver: one frame, each bit held div clocks, driven on negedges
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int div,
                            input int extra_low);
    @(negedge clk);
    uart_line = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_line = b[i];
      repeat (div) @(negedge clk);
    end
    uart_line = stop_bit;
    repeat (div) @(negedge clk);
    if (!stop_bit) repeat (extra_low) @(negedge clk);
    uart_line = 1'b1;
  endtask

  task automatic set_div(input int d);
    logic ack;
    bus_write(4'h8, d, 4'b0011, ack);
    cur_div = int'(model_baud(16'(cur_div), d, 4'b0011));
  endtask

  logic [31:0] rd;
  logic        vld, ack;

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #11;
    n_checks++;
    if ({wready, rvalid, o_rx_irq, rdata} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wready=%b rvalid=%b irq=%b rdata=%h expected all 0",
               wready, rvalid, o_rx_irq, rdata);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(4'h8, rd, vld);
    n_checks++;
    if (rd !== DEF_DIV) begin n_fail++; $display("FAIL reset_bauddiv: got %0d expected %0d", rd, DEF_DIV); end
    bus_read(4'h4, rd, vld);
    n_checks++;
    if (rd !== model_status()) begin n_fail++; $display("FAIL reset_status: got %h expected %h", rd, model_status()); end
  endtask

  task automatic test_default_byte();
    int k, lo, hi;
    k = -1;
    lo = 2 + cur_div / 2 + 9 * cur_div;
    hi = lo + 2;
    fork
      send_frame(8'hA5, 1'b1, cur_div, 0);
      begin
        @(negedge clk);
        for (int i = 1; i < 12 * cur_div; i++) begin
          @(negedge clk);
          if (o_rx_irq) begin k = i; break; end
        end
      end
    join
    model_rx(8'hA5, 1'b1);
    n_checks++;
    if (k < lo || k > hi) begin n_fail++; $display("FAIL irq_timing: got irq at cycle %0d expected %0d..%0d", k, lo, hi); end
    bus_read(4'h4, rd, vld);
    n_checks++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL byte_status: got %h expected 00000001", rd); end
    bus_read(4'h0, rd, vld);
    n_checks++;
    if (rd !== model_pop() || vld !== 1'b1) begin n_fail++; $display("FAIL byte_data: got %h vld=%b expected 000000a5 vld=1", rd, vld); end
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse: got %b expected 0", rvalid); end
    bus_read(4'h4, rd, vld);
    n_checks++;
    if (rd !== model_status()) begin n_fail++; $display("FAIL byte_status_after: got %h expected %h", rd, model_status()); end
  endtask

  task automatic test_bauddiv();
    logic [31:0] wd [4] = '{32'h0000_0010, 32'h0000_AB77, 32'h0000_0002, 32'h0000_0003};
    logic [3:0]  ws [4] = '{4'b0011, 4'b0010, 4'b0011, 4'b0001};
    logic [15:0] exp_b;
    exp_b = 16'(cur_div);
    for (int i = 0; i < 4; i++) begin
      bus_write(4'h8, wd[i], ws[i], ack);
      exp_b = model_baud(exp_b, wd[i], ws[i]);
      if (i == 0) begin
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL wready_pulse: got %b expected 1", ack); end
      end
      bus_read(4'h8, rd, vld);
      n_checks++;
      if (rd !== {16'd0, exp_b}) begin n_fail++; $display("FAIL bauddiv_%0d: got %h expected %h", i, rd, exp_b); end
    end
    cur_div = int'(exp_b);
    bus_read(4'hC, rd, vld);
    n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL reg_0c: got %h expected 0", rd); end
    set_div(16);
  endtask

  task automatic test_fifo_fill();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, cur_div, 0);
      model_rx(8'(i), 1'b1);
    end
    repeat (4) @(negedge clk);
    bus_read(4'h4, rd, vld);
    n_checks++;
    if (rd !== 32'h7 || rd !== model_status()) begin n_fail++; $display("FAIL fill_status: got %h expected %h", rd, model_status()); end
    for (int i = 0; i < 5; i++) begin
      bus_read(4'h0, rd, vld);
      n_checks++;
      if (rd !== model_pop()) begin n_fail++; $display("FAIL fill_read_%0d: got %h", i, rd); end
    end
    bus_read(4'h4, rd, vld);
    n_checks++;
    if (rd !== 32'h4) begin n_fail++; $display("FAIL overrun_only: got %h expected 00000004", rd); end
    bus_write(4'h4, 32'h4, 4'hF, ack);
    model_ovr = 0;
    bus_read(4'h4, rd, vld);
    n_checks++;
    if (rd !== model_status()) begin n_fail++; $display("FAIL overrun_clear: got %h expected %h", rd, model_status()); end
  endtask

  task automatic test_frame_break();
    logic [7:0] b;
    b = 8'($urandom);
    send_frame(b, 1'b0, cur_div, 3 * cur_div);
    model_rx(b, 1'b0);
    repeat (4) @(negedge clk);
    bus_read(4'h4, rd, vld);
    n_checks++;
    if (rd !== 32'h8) begin n_fail++; $display("FAIL frame_err_status: got %h expected 00000008", rd); end
    send_frame(8'h3C, 1'b1, cur_div, 0);
    model_rx(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(4'h4, rd, vld);
    n_checks++;
    if (rd !== model_status()) begin n_fail++; $display("FAIL after_break_status: got %h expected %h", rd, model_status()); end
    bus_read(4'h0, rd, vld);
    n_checks++;
    if (rd !== model_pop()) begin n_fail++; $display("FAIL after_break_data: got %h expected 0000003c", rd); end
    bus_write(4'h4, 32'h8, 4'hF, ack);
    model_ferr = 0;
    bus_read(4'h4, rd, vld);
    n_checks++;
    if (rd !== model_status()) begin n_fail++; $display("FAIL ferr_clear: got %h expected %h", rd, model_status()); end
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    @(negedge clk) uart_line = 1'b0;
    repeat (2) @(negedge clk);
    uart_line = 1'b1;
    repeat (3 * cur_div) @(negedge clk);
    bus_read(4'h4, rd, vld);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL glitch_status: got %h expected 00000000", rd); end
    b = 8'($urandom);
    send_frame(b, 1'b1, cur_div, 0);
    model_rx(b, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(4'h0, rd, vld);
    n_checks++;
    if (rd !== model_pop()) begin n_fail++; $display("FAIL glitch_next_frame: got %h expected %h", rd, b); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] b;
    logic [31:0] oldest;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, cur_div, 0);
      model_rx(b, 1'b1);
    end
    b = 8'($urandom);
    oldest = {24'd0, model_q[0]};
    // Stop-bit sample edge: 2 synchroniser + 1 detection edge + half bit + 9 bits
    fork
      send_frame(b, 1'b1, cur_div, 0);
      begin
        @(negedge clk);
        repeat (2 + cur_div / 2 + 9 * cur_div) @(negedge clk);
        raddr = 32'h0; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0; rd = rdata; vld = rvalid;
      end
    join
    void'(model_pop());
    model_rx(b, 1'b1);
    n_checks++;
    if (rd !== oldest || vld !== 1'b1) begin n_fail++; $display("FAIL simul_pop: got %h vld=%b expected %h", rd, vld, oldest); end
    bus_read(4'h4, rd, vld);
    n_checks++;
    if (rd !== 32'h3 || rd !== model_status()) begin n_fail++; $display("FAIL simul_status: got %h expected 00000003", rd); end
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(4'h0, rd, vld);
      n_checks++;
      if (rd !== model_pop()) begin n_fail++; $display("FAIL simul_drain_%0d: got %h", i, rd); end
    end
  endtask

  task automatic test_random();
    int n;
    logic [7:0] b;
    for (int r = 0; r < 4; r++) begin
      set_div($urandom_range(6, 24));
      bus_read(4'h8, rd, vld);
      n_checks++;
      if (rd !== cur_div) begin n_fail++; $display("FAIL rand_div_%0d: got %0d expected %0d", r, rd, cur_div); end
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        send_frame(b, 1'b1, cur_div, 0);
        model_rx(b, 1'b1);
      end
      repeat (4) @(negedge clk);
      bus_read(4'h4, rd, vld);
      n_checks++;
      if (rd !== model_status()) begin n_fail++; $display("FAIL rand_status_%0d: got %h expected %h", r, rd, model_status()); end
      n = model_q.size() + $urandom_range(0, 1);
      for (int i = 0; i < n; i++) begin
        bus_read(4'h0, rd, vld);
        n_checks++;
        if (rd !== model_pop()) begin n_fail++; $display("FAIL rand_data_%0d_%0d: got %h", r, i, rd); end
      end
      bus_write(4'h4, 32'hC, 4'hF, ack);
      model_ovr = 0;
      model_ferr = 0;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    set_div(16);
    b = 8'($urandom);
    send_frame(b, 1'b1, cur_div, 0);
    model_rx(b, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(4'h4, rd, vld);
    n_checks++;
    if (rd !== model_status()) begin n_fail++; $display("FAIL pre_reset_status: got %h expected %h", rd, model_status()); end
    fork
      send_frame(8'hC3, 1'b1, cur_div, 0);
      begin
        @(negedge clk);
        repeat (cur_div / 2 + 4 * cur_div + 8) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({wready, rvalid, o_rx_irq, rdata} !== 35'd0) begin
          n_fail++;
          $display("FAIL async_reset: got wready=%b rvalid=%b irq=%b rdata=%h expected all 0",
                   wready, rvalid, o_rx_irq, rdata);
        end
      end
    join
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_q.delete();
    model_ovr = 0;
    model_ferr = 0;
    cur_div = DEF_DIV;
    bus_read(4'h4, rd, vld);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL post_reset_status: got %h expected 00000000", rd); end
    send_frame(8'h5A, 1'b1, cur_div, 0);
    model_rx(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(4'h0, rd, vld);
    n_checks++;
    if (rd !== model_pop()) begin n_fail++; $display("FAIL post_reset_data: got %h expected 0000005a", rd); end
  endtask

  initial begin
    test_reset();
    test_default_byte();
    test_bauddiv();
    test_fifo_fill();
    test_frame_break();
    test_glitch();
    test_simultaneous();
    test_random();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
